// File: rtl/ram8_arb_pkg.sv
// Shared types for the ram8 arbiter: FSM states, grant owner and the
// width of the video starvation counter.
package ram8_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_VID  = 2'd2
    } grant_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/ram8.sv
// Single-port RAM: synchronous write, combinational read.
module ram8 #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_en && i_wr) begin
            r_mem[i_addr] <= i_din;
        end
    end

    assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one single-port RAM between a read/write CPU port and a read-only
// video port; every access is a fixed IDLE -> ACCESS -> ACK transaction.
module ram8_arbiter
    import ram8_arb_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int VID_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t                r_state, r_state_next;
    grant_t                r_grant, r_grant_next;
    logic [STREAK_W-1:0]   r_vid_streak, r_vid_streak_next;
    logic                  r_cpu_ack, r_cpu_ack_next;
    logic                  r_vid_ack, r_vid_ack_next;
    logic [DATA_W-1:0]     r_cpu_rdata, r_cpu_rdata_next;
    logic [DATA_W-1:0]     r_vid_rdata, r_vid_rdata_next;
    logic                  r_ram_en, r_ram_en_next;
    logic                  r_ram_wr, r_ram_wr_next;
    logic [ADDR_W-1:0]     r_ram_addr, r_ram_addr_next;
    logic [DATA_W-1:0]     r_ram_din, r_ram_din_next;
    grant_t                w_pick;

    // Video wins unless it has already taken VID_MAX grants in a row while
    // the CPU was waiting.
    function automatic grant_t arbitrate(input logic cpu, input logic vid,
                                         input logic [STREAK_W-1:0] streak);
        grant_t g;
        g = GNT_NONE;
        if (vid && !(cpu && streak == STREAK_W'(VID_MAX))) begin
            g = GNT_VID;
        end else if (cpu) begin
            g = GNT_CPU;
        end
        return g;
    endfunction

    assign w_pick = arbitrate(cpu_req, vid_req, r_vid_streak);

    always_comb begin
        r_state_next      = r_state;
        r_grant_next      = r_grant;
        r_vid_streak_next = r_vid_streak;
        r_cpu_ack_next    = 1'b0;
        r_vid_ack_next    = 1'b0;
        r_cpu_rdata_next  = r_cpu_rdata;
        r_vid_rdata_next  = r_vid_rdata;
        r_ram_en_next     = r_ram_en;
        r_ram_wr_next     = r_ram_wr;
        r_ram_addr_next   = r_ram_addr;
        r_ram_din_next    = r_ram_din;
        case (r_state)
            ST_IDLE: begin
                if (w_pick == GNT_CPU) begin
                    r_grant_next      = GNT_CPU;
                    r_state_next      = ST_ACCESS;
                    r_ram_en_next     = 1'b1;
                    r_ram_wr_next     = cpu_wr;
                    r_ram_addr_next   = cpu_addr;
                    r_ram_din_next    = cpu_wdata;
                    r_vid_streak_next = '0;
                end else if (w_pick == GNT_VID) begin
                    r_grant_next    = GNT_VID;
                    r_state_next    = ST_ACCESS;
                    r_ram_en_next   = 1'b1;
                    r_ram_wr_next   = 1'b0;
                    r_ram_addr_next = vid_addr;
                    if (!cpu_req) begin
                        r_vid_streak_next = '0;
                    end else if (r_vid_streak < STREAK_W'(VID_MAX)) begin
                        r_vid_streak_next = r_vid_streak + 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_grant == GNT_CPU) begin
                    r_cpu_ack_next = 1'b1;
                    if (!r_ram_wr) begin
                        r_cpu_rdata_next = ram_dout;
                    end
                end else if (r_grant == GNT_VID) begin
                    r_vid_ack_next   = 1'b1;
                    r_vid_rdata_next = ram_dout;
                end
                r_ram_en_next = 1'b0;
                r_ram_wr_next = 1'b0;
                r_state_next  = ST_ACK;
            end
            ST_ACK: begin
                // Requests may still show the finished access here, so no arbitration.
                r_grant_next = GNT_NONE;
                r_state_next = ST_IDLE;
            end
            default: begin
                r_grant_next = GNT_NONE;
                r_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_NONE;
            r_vid_streak <= '0;
            r_cpu_ack    <= 1'b0;
            r_vid_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vid_rdata  <= '0;
            r_ram_en     <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
        end else begin
            r_state      <= r_state_next;
            r_grant      <= r_grant_next;
            r_vid_streak <= r_vid_streak_next;
            r_cpu_ack    <= r_cpu_ack_next;
            r_vid_ack    <= r_vid_ack_next;
            r_cpu_rdata  <= r_cpu_rdata_next;
            r_vid_rdata  <= r_vid_rdata_next;
            r_ram_en     <= r_ram_en_next;
            r_ram_wr     <= r_ram_wr_next;
            r_ram_addr   <= r_ram_addr_next;
            r_ram_din    <= r_ram_din_next;
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign vid_ack   = r_vid_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign vid_rdata = r_vid_rdata;
    assign ram_en    = r_ram_en;
    assign ram_wr    = r_ram_wr;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed self-checking bench for ram8_arbiter driving a real ram8 instance.
module tb_ram8_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;
    logic              ram_en, ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram8_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VID_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    ram8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk(clk), .i_en(ram_en), .i_wr(ram_wr), .i_addr(ram_addr),
        .i_din(ram_din), .o_dout(ram_dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    // Issues one CPU access from IDLE; edges = rising edges from req to ack, -1 on timeout.
    task automatic run_cpu(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, output int edges, output logic saw_vid);
        step();
        cpu_wr = wr; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
        edges = 0; saw_vid = 1'b0;
        while (1) begin
            step();
            edges++;
            if (vid_ack) saw_vid = 1'b1;
            if (cpu_ack) break;
            if (edges >= 20) begin edges = -1; break; end
        end
        cpu_req = 1'b0;
        $display("tb: cpu %s addr=%h wdata=%h edges=%0d rdata=%h", wr ? "wr" : "rd", addr, data, edges, cpu_rdata);
    endtask

    task automatic run_vid(input logic [ADDR_W-1:0] addr, output int edges,
                           output logic saw_cpu, output logic saw_wr);
        step();
        vid_addr = addr; vid_req = 1'b1;
        edges = 0; saw_cpu = 1'b0; saw_wr = 1'b0;
        while (1) begin
            step();
            edges++;
            if (cpu_ack) saw_cpu = 1'b1;
            if (ram_wr) saw_wr = 1'b1;
            if (vid_ack) break;
            if (edges >= 20) begin edges = -1; break; end
        end
        vid_req = 1'b0;
        $display("tb: vid rd addr=%h edges=%0d rdata=%h", addr, edges, vid_rdata);
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        do_reset();
        flags = {cpu_ack, vid_ack, ram_en, ram_wr, |cpu_rdata, |vid_rdata, |ram_addr, |ram_din};
        checks++;
        if (flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b want 00000000", flags);
        end
        $display("tb: reset outputs flags=%b", flags);
    endtask

    task automatic test_cpu_write_read();
        int e; logic sv;
        run_cpu(1'b1, 15'h0123, 8'h5A, e, sv);
        checks++; if (e !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", e); end
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL wr_no_vid_ack: got %b want 0", sv); end
        step();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b want 0", cpu_ack); end
        run_cpu(1'b0, 15'h0123, 8'h00, e, sv);
        checks++; if (e !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", e); end
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h want 5a", cpu_rdata); end
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL rd_no_vid_ack: got %b want 0", sv); end
    endtask

    task automatic test_vid_read();
        int e; logic sv, sc, sw;
        run_cpu(1'b1, 15'h7FFF, 8'hC3, e, sv);
        run_vid(15'h7FFF, e, sc, sw);
        checks++; if (e !== 2) begin errors++; $display("FAIL vid_latency: got %0d want 2", e); end
        checks++; if (vid_rdata !== 8'hC3) begin errors++; $display("FAIL vid_data: got %h want c3", vid_rdata); end
        checks++; if (sw !== 1'b0) begin errors++; $display("FAIL vid_ram_wr: got %b want 0", sw); end
        checks++; if (sc !== 1'b0) begin errors++; $display("FAIL vid_no_cpu_ack: got %b want 0", sc); end
    endtask

    task automatic test_cpu_during_vid();
        int e, vid_edge; logic both;
        step();
        vid_addr = 15'h7FFF; vid_req = 1'b1;
        step();
        cpu_wr = 1'b0; cpu_addr = 15'h0123; cpu_req = 1'b1;
        e = 0; vid_edge = -1; both = 1'b0;
        while (1) begin
            step();
            e++;
            if (cpu_ack && vid_ack) both = 1'b1;
            if (vid_ack) begin vid_edge = e; vid_req = 1'b0; end
            if (cpu_ack) break;
            if (e >= 20) begin e = -1; break; end
        end
        cpu_req = 1'b0;
        $display("tb: contended vid_edge=%0d cpu_edge=%0d rdata=%h", vid_edge, e, cpu_rdata);
        checks++; if (vid_edge !== 1) begin errors++; $display("FAIL contend_vid_first: got %0d want 1", vid_edge); end
        checks++; if (e !== 4) begin errors++; $display("FAIL contend_cpu_latency: got %0d want 4", e); end
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL contend_cpu_data: got %h want 5a", cpu_rdata); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL contend_overlap: got %b want 0", both); end
    endtask

    task automatic test_streak();
        string seq;
        int e, n, last, bad_gap, overlap;
        do_reset();
        cpu_wr = 1'b0; cpu_addr = 15'h0123; vid_addr = 15'h7FFF;
        cpu_req = 1'b1; vid_req = 1'b1;
        seq = ""; e = 0; n = 0; last = -1; bad_gap = 0; overlap = 0;
        while (n < 10 && e < 60) begin
            step();
            e++;
            if (cpu_ack && vid_ack) overlap++;
            if (cpu_ack || vid_ack) begin
                seq = {seq, vid_ack ? "V" : "C"};
                if ((last < 0 && e != 2) || (last >= 0 && e - last != 3)) bad_gap++;
                last = e;
                n++;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        $display("tb: streak seq=%s edges=%0d", seq, e);
        checks++; if (seq != "VVVVCVVVVC") begin errors++; $display("FAIL streak_seq: got %s want VVVVCVVVVC", seq); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL streak_spacing: got %0d bad gaps want 0", bad_gap); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL streak_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_reset_during_write();
        int e; logic sv; logic [7:0] flags;
        run_cpu(1'b1, 15'h0040, 8'h22, e, sv);
        step();
        cpu_wr = 1'b1; cpu_addr = 15'h0040; cpu_wdata = 8'h11; cpu_req = 1'b1;
        step();
        checks++; if ({ram_en, ram_wr} !== 2'b11) begin errors++; $display("FAIL rst_access_strobes: got %b want 11", {ram_en, ram_wr}); end
        reset = 1'b1; cpu_req = 1'b0;
        step();
        flags = {cpu_ack, vid_ack, ram_en, ram_wr, |cpu_rdata, |vid_rdata, |ram_addr, |ram_din};
        $display("tb: reset in access flags=%b", flags);
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rst_access_outputs: got flags=%b want 00000000", flags); end
        reset = 1'b0;
        run_cpu(1'b0, 15'h0040, 8'h00, e, sv);
        checks++; if (cpu_rdata !== 8'h11) begin errors++; $display("FAIL rst_write_committed: got %h want 11", cpu_rdata); end
        checks++; if (e !== 2) begin errors++; $display("FAIL rst_reissue_latency: got %0d want 2", e); end
    endtask

    task automatic test_rdata_hold();
        int e; logic sv;
        run_cpu(1'b1, 15'h0200, 8'hAA, e, sv);
        run_cpu(1'b0, 15'h0200, 8'h00, e, sv);
        checks++; if (cpu_rdata !== 8'hAA) begin errors++; $display("FAIL hold_read: got %h want aa", cpu_rdata); end
        run_cpu(1'b1, 15'h0201, 8'h55, e, sv);
        checks++; if (cpu_rdata !== 8'hAA) begin errors++; $display("FAIL hold_at_wr_ack: got %h want aa", cpu_rdata); end
        step();
        checks++; if (cpu_rdata !== 8'hAA) begin errors++; $display("FAIL hold_after_wr: got %h want aa", cpu_rdata); end
        run_cpu(1'b0, 15'h0201, 8'h00, e, sv);
        checks++; if (cpu_rdata !== 8'h55) begin errors++; $display("FAIL hold_second_read: got %h want 55", cpu_rdata); end
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        test_reset();
        test_cpu_write_read();
        test_vid_read();
        test_cpu_during_vid();
        test_streak();
        test_reset_during_write();
        test_rdata_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
